// File: rtl/mux_seq_nx1.sv
// Registered N:1 multiplexer with a latched select, auto-scan and select range checking.
// Define MUX_HOLD_EN to add a `hold` input that freezes the select and output registers.
module mux_seq_nx1 #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  sel_load,
  input  logic                  mode,
`ifdef MUX_HOLD_EN
  input  logic                  hold,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  output logic                  scan_wrap,
  output logic                  sel_err
);

  localparam int unsigned NumSlots = 2 ** SEL_W;
  localparam logic [SEL_W:0]   NInW    = (SEL_W + 1)'(N_IN);
  localparam logic [SEL_W-1:0] LastSel = SEL_W'(N_IN - 1);

  // Unused slots above N_IN read as zero so the select can index the array at full width.
  logic [WIDTH-1:0] chan [NumSlots];

  for (genvar k = 0; k < NumSlots; k++) begin : g_chan
    if (k < N_IN) begin : g_used
      assign chan[k] = data_in[k*WIDTH +: WIDTH];
    end else begin : g_unused
      assign chan[k] = '0;
    end
  end

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] osel_q, osel_d;
  logic             valid_q;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             sel_ok;
  logic             at_last;
  logic             frozen;

`ifdef MUX_HOLD_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    sel_ok  = {1'b0, sel_in} < NInW;
    at_last = (sel_q == LastSel);
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = chan[sel_q];
    osel_d  = sel_q;

    if (sel_load && !sel_ok) begin
      err_d = 1'b1;
    end else if (sel_load) begin
      sel_d = sel_in;
    end else if (mode) begin
      sel_d  = at_last ? '0 : sel_q + SEL_W'(1);
      wrap_d = at_last;
    end

    // Range check still reports while frozen; everything else holds.
    if (frozen) begin
      sel_d  = sel_q;
      wrap_d = 1'b0;
      data_d = data_q;
      osel_d = osel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      data_q  <= '0;
      osel_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      valid_q <= 1'b1;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign out_valid = valid_q;
  assign scan_wrap = wrap_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_seq_nx1.sv
// Directed bench for mux_seq_nx1: an 8x1-bit instance and a 5x4-bit instance share clk/rst.
module tb_mux_seq_nx1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  d8    = '0;
  logic [2:0]  si8   = '0;
  logic        ld8   = 1'b0;
  logic        md8   = 1'b0;
  logic        h8    = 1'b0;
  logic [0:0]  od8;
  logic [2:0]  os8;
  logic        ov8, sw8, se8;

  logic [19:0] d5    = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
  logic [2:0]  si5   = '0;
  logic        ld5   = 1'b0;
  logic        md5   = 1'b0;
  logic        h5    = 1'b0;
  logic [3:0]  od5;
  logic [2:0]  os5;
  logic        ov5, sw5, se5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_seq_nx1 #(.N_IN(8), .WIDTH(1), .SEL_W(3)) u8 (
    .clk(clk), .rst(rst), .data_in(d8), .sel_in(si8), .sel_load(ld8), .mode(md8),
`ifdef MUX_HOLD_EN
    .hold(h8),
`endif
    .out_data(od8), .out_sel(os8), .out_valid(ov8), .scan_wrap(sw8), .sel_err(se8)
  );

  mux_seq_nx1 #(.N_IN(5), .WIDTH(4), .SEL_W(3)) u5 (
    .clk(clk), .rst(rst), .data_in(d5), .sel_in(si5), .sel_load(ld5), .mode(md5),
`ifdef MUX_HOLD_EN
    .hold(h5),
`endif
    .out_data(od5), .out_sel(os5), .out_valid(ov5), .scan_wrap(sw5), .sel_err(se5)
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; the next edge is the first one after release.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({od8, os8, ov8, sw8, se8} !== 7'd0) begin
      bad++; $display("FAIL reset_u8 got=%b want=0", {od8, os8, ov8, sw8, se8});
    end
    total++; if ({od5, os5, ov5, sw5, se5} !== 10'd0) begin
      bad++; $display("FAIL reset_u5 got=%b want=0", {od5, os5, ov5, sw5, se5});
    end
    step();
    total++; if (ov8 !== 1'b0) begin
      bad++; $display("FAIL reset_hold_valid got=%b want=0", ov8);
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_manual_load();
    d8 = 8'b10111111; md8 = 1'b0; si8 = 3'd6; ld8 = 1'b1;
    step();
    ld8 = 1'b0;
    total++; if (ov8 !== 1'b1 || os8 !== 3'd0 || od8 !== 1'b1) begin
      bad++; $display("FAIL first_edge got valid=%b sel=%0d data=%b want 1 0 1", ov8, os8, od8);
    end
    total++; if (ov5 !== 1'b1 || os5 !== 3'd0 || od5 !== 4'hA) begin
      bad++; $display("FAIL first_edge_u5 got valid=%b sel=%0d data=%h want 1 0 a", ov5, os5, od5);
    end
    step();
    total++; if (os8 !== 3'd6 || od8 !== 1'b0) begin
      bad++; $display("FAIL load6 got sel=%0d data=%b want 6 0", os8, od8);
    end
    step();
    total++; if (os8 !== 3'd6 || od8 !== 1'b0 || se8 !== 1'b0) begin
      bad++; $display("FAIL load6_hold got sel=%0d data=%b err=%b want 6 0 0", os8, od8, se8);
    end
  endtask

  task automatic test_manual_pair();
    d8 = 8'b01010101; si8 = 3'd0; ld8 = 1'b1;
    step();
    si8 = 3'd1;
    step();
    ld8 = 1'b0;
    total++; if (os8 !== 3'd0 || od8 !== 1'b1 || ov8 !== 1'b1) begin
      bad++; $display("FAIL pair_ch0 got sel=%0d data=%b valid=%b want 0 1 1", os8, od8, ov8);
    end
    step();
    total++; if (os8 !== 3'd1 || od8 !== 1'b0 || ov8 !== 1'b1) begin
      bad++; $display("FAIL pair_ch1 got sel=%0d data=%b valid=%b want 1 0 1", os8, od8, ov8);
    end
  endtask

  task automatic test_auto_scan();
    logic [2:0] exp_sel  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [3:0] exp_data [7] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hA, 4'hB};
    logic       exp_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    md5 = 1'b1;
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (os5 !== exp_sel[i] || od5 !== exp_data[i] || sw5 !== exp_wrap[i]) begin
        bad++;
        $display("FAIL scan_%0d got sel=%0d data=%h wrap=%b want %0d %h %b",
                 i, os5, od5, sw5, exp_sel[i], exp_data[i], exp_wrap[i]);
      end
    end
  endtask

  // Continues from select register = 2 left by test_auto_scan.
  task automatic test_sel_err();
    si5 = 3'd7; ld5 = 1'b1;
    step();
    ld5 = 1'b0;
    total++; if (se5 !== 1'b1 || os5 !== 3'd2 || sw5 !== 1'b0) begin
      bad++; $display("FAIL err_pulse got err=%b sel=%0d wrap=%b want 1 2 0", se5, os5, sw5);
    end
    step();
    total++; if (se5 !== 1'b0 || os5 !== 3'd2) begin
      bad++; $display("FAIL err_hold got err=%b sel=%0d want 0 2", se5, os5);
    end
    step();
    total++; if (os5 !== 3'd3 || od5 !== 4'hD) begin
      bad++; $display("FAIL err_resume got sel=%0d data=%h want 3 d", os5, od5);
    end
    // In-range load during auto-scan: scan continues from the loaded index.
    si5 = 3'd1; ld5 = 1'b1;
    step();
    ld5 = 1'b0;
    total++; if (os5 !== 3'd4 || se5 !== 1'b0) begin
      bad++; $display("FAIL auto_load got sel=%0d err=%b want 4 0", os5, se5);
    end
    step();
    total++; if (os5 !== 3'd1 || sw5 !== 1'b0) begin
      bad++; $display("FAIL auto_load_at got sel=%0d wrap=%b want 1 0", os5, sw5);
    end
    step();
    total++; if (os5 !== 3'd2 || od5 !== 4'hC) begin
      bad++; $display("FAIL auto_load_next got sel=%0d data=%h want 2 c", os5, od5);
    end
  endtask

  // Select register is 3 here; reset lands mid-cycle with no clock edge.
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if ({od5, os5, ov5, sw5, se5} !== 10'd0) begin
      bad++; $display("FAIL async_rst got=%b want=0", {od5, os5, ov5, sw5, se5});
    end
    rst = 1'b0;
    step();
    total++; if (ov5 !== 1'b1 || os5 !== 3'd0 || od5 !== 4'hA) begin
      bad++; $display("FAIL post_rst got valid=%b sel=%0d data=%h want 1 0 a", ov5, os5, od5);
    end
    step();
    total++; if (os5 !== 3'd1) begin
      bad++; $display("FAIL post_rst_scan got sel=%0d want 1", os5);
    end
  endtask

`ifdef MUX_HOLD_EN
  task automatic test_hold();
    md5 = 1'b1;
    pulse_reset();
    step(); step(); step();
    total++; if (os5 !== 3'd2) begin
      bad++; $display("FAIL hold_pre got sel=%0d want 2", os5);
    end
    h5 = 1'b1; si5 = 3'd6; ld5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ld5 = 1'b0;
      total++;
      if (os5 !== 3'd2 || od5 !== 4'hC || sw5 !== 1'b0 || se5 !== (i == 0)) begin
        bad++;
        $display("FAIL hold_%0d got sel=%0d data=%h wrap=%b err=%b want 2 c 0 %b",
                 i, os5, od5, sw5, se5, i == 0);
      end
    end
    h5 = 1'b0;
    step();
    total++; if (os5 !== 3'd3 || od5 !== 4'hD) begin
      bad++; $display("FAIL hold_rel got sel=%0d data=%h want 3 d", os5, od5);
    end
    step();
    total++; if (os5 !== 3'd4 || sw5 !== 1'b1) begin
      bad++; $display("FAIL hold_wrap got sel=%0d wrap=%b want 4 1", os5, sw5);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_manual_load();
    test_manual_pair();
    test_auto_scan();
    test_sel_err();
    test_async_reset();
`ifdef MUX_HOLD_EN
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
